ifetch_m: RTL and testbench

//  Instruction fetch stage: owns the PC and drives the instruction memory address.

---
 rtl/ifetch_m.sv | 128 ++++++++++++
 tb/tb_ifetch_m.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_m.sv
// Instruction fetch stage: owns the PC, drives the instruction memory and buffers fetched words
// in a small queue toward decode. Define IF_MISALIGN_EN to trap misaligned redirects.
module ifetch_m #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       QDEPTH   = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [INSTR_W-1:0] ILLEGAL  = '0
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic               im_ready,
  input  logic [INSTR_W-1:0] im_instr,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic [INSTR_W-1:0] dec_instr,
  output logic               fetch_misalign
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(QDEPTH);
  localparam logic [PTR_W:0] CNT_LAST = CNT_FULL - 1'b1;

  typedef enum logic [1:0] {StIdle, StFetch, StFull} state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  pc, pc_next;
  logic               lock, lock_next;
  logic               misalign, misalign_next;

  logic [ADDR_W-1:0]  q_pc    [QDEPTH];
  logic [INSTR_W-1:0] q_instr [QDEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [PTR_W:0]     count;

  logic               full, push, pop, redir_bad;
  logic [ADDR_W-1:0]  redir_tgt;

`ifdef IF_MISALIGN_EN
  assign redir_bad = |redir_pc[1:0];
  assign redir_tgt = redir_pc;
`else
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^redir_pc[1:0];
  assign redir_bad = 1'b0;
  assign redir_tgt = {redir_pc[ADDR_W-1:2], 2'b00};
`endif

  assign full      = (count == CNT_FULL);
  assign dec_valid = (count != '0);
  // A redirect discards both the incoming word and any decode handshake of the same cycle.
  assign pop  = dec_valid & dec_ready & ~redir_valid;
  assign push = (state == StFetch) & im_ready & (~full | pop) & ~redir_valid;

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    lock_next     = lock;
    misalign_next = 1'b0;
    if (redir_valid) begin
      if (redir_bad) begin
        state_next    = StIdle;
        lock_next     = 1'b1;
        misalign_next = 1'b1;
      end else begin
        pc_next    = redir_tgt;
        lock_next  = 1'b0;
        state_next = fetch_en ? StFetch : StIdle;
      end
    end else begin
      case (state)
        StIdle: if (fetch_en && !lock) state_next = StFetch;
        StFetch: begin
          if (push) pc_next = pc + ADDR_W'(4);
          if (push && !pop && count == CNT_LAST) state_next = StFull;
          else if (!fetch_en)                    state_next = StIdle;
        end
        StFull:  if (pop) state_next = StFetch;
        default: state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state    <= StIdle;
      pc       <= RESET_PC;
      lock     <= 1'b0;
      misalign <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      lock     <= lock_next;
      misalign <= misalign_next;
      if (redir_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= im_instr;
    end
  end

  assign im_addr        = pc;
  assign dec_pc         = dec_valid ? q_pc[rd_ptr] : '0;
  assign dec_instr      = dec_valid ? q_instr[rd_ptr] : ILLEGAL;
  assign fetch_misalign = misalign;

endmodule

// File: tb/tb_ifetch_m.sv
// Randomized scoreboard bench for ifetch_m: expected {pc,instr} stream is generated from the
// redirect/reset targets; a negedge monitor checks every decode handshake against it.
module tb_ifetch_m;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] ILLEGAL  = 32'h0;

  logic        clk = 1'b0;
  logic        srst, fetch_en, im_ready, redir_valid, dec_ready;
  logic [31:0] im_addr, im_instr, redir_pc, dec_pc, dec_instr;
  logic        dec_valid, fetch_misalign;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_pop  = 0;

  logic [63:0] exp_q[$];
  logic [31:0] next_exp;
  bit          active;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign im_instr = mem(im_addr);

  ifetch_m #(
    .ADDR_W(32), .INSTR_W(32), .QDEPTH(2), .RESET_PC(RESET_PC), .ILLEGAL(ILLEGAL)
  ) dut (
    .clk(clk), .srst(srst), .fetch_en(fetch_en), .im_addr(im_addr), .im_ready(im_ready),
    .im_instr(im_instr), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .fetch_misalign(fetch_misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic topup();
    while (active && exp_q.size() < 16) begin
      exp_q.push_back({next_exp, mem(next_exp)});
      next_exp = next_exp + 32'd4;
    end
  endtask

  task automatic set_base(input logic [31:0] a, input bit act);
    exp_q.delete();
    next_exp = a;
    active   = act;
    topup();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic do_reset();
    srst = 1'b1; fetch_en = 1'b0; im_ready = 1'b0; dec_ready = 1'b0;
    redir_valid = 1'b0; redir_pc = '0;
    set_base(RESET_PC, 1'b1);
    cyc(); cyc();
    srst = 1'b0;
  endtask

  // Redirect with the architectural outcome of the target decided here, not in the DUT.
  task automatic redirect(input logic [31:0] a);
    redir_valid = 1'b1;
    redir_pc    = a;
`ifdef IF_MISALIGN_EN
    if (a[1:0] != 2'b00) set_base(a, 1'b0);
    else                 set_base(a, 1'b1);
`else
    set_base({a[31:2], 2'b00}, 1'b1);
`endif
  endtask

  task automatic wait_first(input string name, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (dec_valid) seen = 1'b1;
      else cyc();
    end
    if (seen) chk(name, dec_pc, exp_pc);
    else begin
      n_cmp++; n_fail++;
      $display("FAIL %s: got no dec_valid expected pc %h", name, exp_pc);
    end
  endtask

  always @(negedge clk) begin
    if (!srst && !redir_valid && dec_valid && dec_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_pop: got pc %h expected none", dec_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", dec_pc, e[63:32]);
        chk("pop_instr", dec_instr, e[31:0]);
      end
    end
  end

  initial begin
    logic [31:0] a0;
    bit          r;
    do_reset();
    chk("rst_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_addr", im_addr, RESET_PC);
    chk("rst_pc", dec_pc, 32'd0);
    chk("rst_instr", dec_instr, ILLEGAL);
    chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);

    // Streaming at full rate.
    fetch_en = 1'b1; im_ready = 1'b1; dec_ready = 1'b1;
    cyc(); cyc();
    for (int i = 0; i < 10; i++) begin
      chk("stream_valid", {31'b0, dec_valid}, 32'd1);
      cyc();
    end

    // Backpressure fills the queue and holds the fetch address.
    do_reset();
    fetch_en = 1'b1; im_ready = 1'b1; dec_ready = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("full_addr", im_addr, 32'h8);
    chk("full_head", dec_pc, 32'h0);
    chk("full_valid", {31'b0, dec_valid}, 32'd1);
    dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) cyc();

    // Sparse memory responses: address moves only after an im_ready cycle.
    do_reset();
    fetch_en = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      im_ready = (i % 4 == 0);
      a0 = im_addr;
      r  = im_ready;
      cyc();
      if (!r) chk("im_hold", im_addr, a0);
    end
    chk("sparse_addr_moved", {31'b0, im_addr > 32'h8}, 32'd1);

    // Redirect while the queue is full.
    do_reset();
    fetch_en = 1'b1; im_ready = 1'b1; dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    redirect(32'h100);
    cyc();
    redir_valid = 1'b0;
    chk("redir_valid", {31'b0, dec_valid}, 32'd0);
    chk("redir_addr", im_addr, 32'h100);
    dec_ready = 1'b1;
    wait_first("redir_first", 32'h100);
    for (int i = 0; i < 4; i++) cyc();

    // Reset while full.
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    srst = 1'b1; fetch_en = 1'b0;
    set_base(RESET_PC, 1'b1);
    cyc();
    srst = 1'b0;
    chk("srst_valid", {31'b0, dec_valid}, 32'd0);
    chk("srst_addr", im_addr, RESET_PC);
    chk("srst_instr", dec_instr, ILLEGAL);
    for (int i = 0; i < 3; i++) cyc();
    chk("srst_idle_addr", im_addr, RESET_PC);
    chk("srst_idle_valid", {31'b0, dec_valid}, 32'd0);

    // Misaligned redirect.
    fetch_en = 1'b1; im_ready = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    redirect(32'h102);
    cyc();
    redir_valid = 1'b0;
`ifdef IF_MISALIGN_EN
    chk("mis_pulse", {31'b0, fetch_misalign}, 32'd1);
    chk("mis_valid", {31'b0, dec_valid}, 32'd0);
    a0 = im_addr;
    cyc();
    chk("mis_pulse_end", {31'b0, fetch_misalign}, 32'd0);
    for (int i = 0; i < 4; i++) cyc();
    chk("mis_no_fetch", im_addr, a0);
    chk("mis_still_empty", {31'b0, dec_valid}, 32'd0);
    redirect(32'h104);
    cyc();
    redir_valid = 1'b0;
    wait_first("mis_resume", 32'h104);
`else
    chk("mis_addr", im_addr, 32'h100);
    chk("mis_pulse", {31'b0, fetch_misalign}, 32'd0);
    wait_first("mis_forced", 32'h100);
`endif
    for (int i = 0; i < 4; i++) cyc();

    // Randomized traffic with redirects, wrap-around and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      fetch_en    = ($urandom % 8) != 0;
      im_ready    = ($urandom % 2) != 0;
      dec_ready   = ($urandom % 3) != 0;
      redir_valid = 1'b0;
      srst        = 1'b0;
      if (i == 100) redirect(32'hFFFF_FFF0);
      else if ($urandom % 40 == 0) begin
        a0 = $urandom;
        if ($urandom % 4 != 0) a0[1:0] = 2'b00;
        redirect(a0);
      end
      if ($urandom % 250 == 0) begin
        srst = 1'b1;
        set_base(RESET_PC, 1'b1);
      end
      cyc();
    end
    srst = 1'b0; redir_valid = 1'b0;
    cyc();
    chk("enough_pops", {31'b0, n_pop > 300}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
